seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for the 8-digit 7-segment display.
//  - Divides clk down to a per-digit dwell period and steps a 3-bit digit index 0..7.
//  - Drives the 3-to-8 active-low digit-select decoder input with that index.
//  - Muxes the matching nibble of a 32-bit display word into active-low segment patterns.
//  - Supports per-digit enable, decimal points and a tear-free frame-boundary update.
// PARAMETERS
//  CLK_DIV      100000  clk cycles per digit dwell (>=4); 1 kHz/digit at 100 MHz
//  BLANK_CYCLES 16      anti-ghost blank cycles at start of each dwell (< CLK_DIV)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  data         in   32  display word; digit k shows data[4k+3:4k]
//  dp_in        in   8   decimal point per digit, 1 = lit
//  digit_en     in   8   per-digit enable, 1 = shown, 0 = blanked
//  load         in   1   1-cycle strobe: capture data/dp_in/digit_en into shadow regs
//  scan_idx     out  3   current digit index, to select-decoder input
//  an           out  8   active-low digit anodes (one-hot-low or all 1s)
//  seg          out  7   active-low segments {g,f,e,d,c,b,a}
//  dp           out  1   active-low decimal point
//  frame_done   out  1   1-cycle pulse when digit 7 dwell ends (idx 7->0)
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//  - prescaler=0, scan_idx=0; shadow and active regs = 0 (all digits disabled).
//  - an=8'hFF, seg=7'h7F, dp=1, frame_done=0.
//  Prescaler:
//  - Counts 0..CLK_DIV-1; tick when count==CLK_DIV-1; count wraps to 0.
//  - On tick, scan_idx <= scan_idx+1, mod 8 (7 wraps to 0).
//  - frame_done=1 in the cycle after a tick that moved scan_idx 7->0; otherwise 0.
//  Shadow/active registers:
//  - load=1 captures data, dp_in, digit_en into shadow on that edge.
//  - Active regs take shadow on the same edge as the tick moving idx 7->0.
//  - load and that tick in the same cycle: active gets the OLD shadow; new value
//    appears next frame. No mid-frame change of displayed content.
//  Output stage, registered, 1-cycle latency from scan_idx/count:
//  - Blank phase: count < BLANK_CYCLES, or active digit_en[scan_idx]==0.
//    Drives an=8'hFF, seg=7'h7F, dp=1.
//  - Otherwise:
//    an  = ~(8'b1 << scan_idx), i.e. the same code as the select decoder.
//    seg = hex pattern of active nibble[scan_idx].
//    dp  = ~active dp[scan_idx].
//  - Hex table, gfedcba active low:
//    0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010
//    7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001
//    E=0000110 F=0001110
//  Invariants:
//  - an never has more than one 0 bit.
//  - an changes only via an all-1s cycle (blank), so there is no overlap.
//  - rst mid-dwell: next cycle equals the reset state; scan restarts at digit 0.
//    Displayed content stays blank until a load followed by a frame wrap.
// TESTING  (CLK_DIV=8, BLANK_CYCLES=2)
//  1 Reset for 3 cycles, release -> an=FF, seg=7F, dp=1, scan_idx=0.
//    scan_idx steps every 8 clk; frame_done pulses every 64 clk.
//  2 load data=32'h76543210, digit_en=FF, dp_in=0, wait one frame.
//    -> digit 3 dwell shows an=F7, seg=0110000 after 2 blank cycles.
//    -> digit 0 dwell shows an=FE, seg=1000000.
//  3 digit_en=8'b1010_1010 -> an stays FF during even-digit dwells.
//    -> odd digits show normally; an never has two 0 bits.
//  4 load data=32'hFEDCBA98 at the cycle of the 7->0 tick.
//    -> the following frame still shows the old word; the frame after shows F on digit 7.
//  5 dp_in=8'h01 -> dp=0 only while an=FE and not blanking; dp=1 otherwise.
//  6 Assert rst while scan_idx=5, mid-dwell.
//    -> next cycle an=FF, scan_idx=0, prescaler=0.
//    -> all digits blank until load plus frame wrap.

Source files
------------

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_ctrl
// Description : Time-multiplexed scan controller for an 8-digit, active-low
//               7-segment display with shadowed display content, per-digit
//               enables, decimal points and anti-ghost blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl #(
    parameter int unsigned CLK_DIV      = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
    input  logic        load,
    output logic [2:0]  scan_idx,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_END = c_CNT_W'(BLANK_CYCLES);
    localparam logic [2:0]         c_LAST_IDX  = 3'd7;

    logic [c_CNT_W-1:0] r_count;
    logic [2:0]         r_idx;
    logic               r_frame_done;

    logic [31:0] r_sh_data;
    logic [7:0]  r_sh_dp;
    logic [7:0]  r_sh_en;
    logic [31:0] r_act_data;
    logic [7:0]  r_act_dp;
    logic [7:0]  r_act_en;

    logic [7:0] r_an;
    logic [6:0] r_seg;
    logic       r_dp;

    logic       w_tick;
    logic       w_wrap;
    logic       w_blank;
    logic [3:0] w_nibble;
    logic [6:0] w_hex;

    // Hex digit to active-low {g,f,e,d,c,b,a} segment pattern
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'h0:    p = 7'b1000000;
            4'h1:    p = 7'b1111001;
            4'h2:    p = 7'b0100100;
            4'h3:    p = 7'b0110000;
            4'h4:    p = 7'b0011001;
            4'h5:    p = 7'b0010010;
            4'h6:    p = 7'b0000010;
            4'h7:    p = 7'b1111000;
            4'h8:    p = 7'b0000000;
            4'h9:    p = 7'b0010000;
            4'hA:    p = 7'b0001000;
            4'hB:    p = 7'b0000011;
            4'hC:    p = 7'b1000110;
            4'hD:    p = 7'b0100001;
            4'hE:    p = 7'b0000110;
            default: p = 7'b0001110;
        endcase
        return p;
    endfunction

    // Dwell-end tick, frame wrap detection and current-digit decode
    always_comb begin
        w_tick   = (r_count == c_CNT_MAX);
        w_wrap   = w_tick && (r_idx == c_LAST_IDX);
        w_blank  = (r_count < c_BLANK_END) || !r_act_en[r_idx];
        w_nibble = r_act_data[{r_idx, 2'b00} +: 4];
        w_hex    = hex7(w_nibble);
    end

    // Prescaler, digit index and frame-done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_count      <= w_tick ? '0 : r_count + 1'b1;
            r_idx        <= w_tick ? r_idx + 3'd1 : r_idx;
            r_frame_done <= w_wrap;
        end
    end

    // Shadow capture on load; active copy only at the frame boundary so the
    // visible content never changes mid-frame (a coincident load lands next frame)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_data  <= '0;
            r_sh_dp    <= '0;
            r_sh_en    <= '0;
            r_act_data <= '0;
            r_act_dp   <= '0;
            r_act_en   <= '0;
        end else begin
            if (load) begin
                r_sh_data <= data;
                r_sh_dp   <= dp_in;
                r_sh_en   <= digit_en;
            end
            if (w_wrap) begin
                r_act_data <= r_sh_data;
                r_act_dp   <= r_sh_dp;
                r_act_en   <= r_sh_en;
            end
        end
    end

    // Registered output stage; the blank window at each dwell start keeps
    // consecutive anodes from overlapping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= 8'hFF;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else if (w_blank) begin
            r_an  <= 8'hFF;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= ~(8'b1 << r_idx);
            r_seg <= w_hex;
            r_dp  <= ~r_act_dp[r_idx];
        end
    end

    assign scan_idx   = r_idx;
    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_ctrl
// Description : Directed, table-driven bench for seven_seg_scan_ctrl with
//               CLK_DIV=8, BLANK_CYCLES=2. Edge count n runs from the last
//               reset release; outputs after edge n reflect the scan state of
//               edge n-1 (count=(n-1)%8, digit=((n-1)/8)%8), scan_idx=(n/8)%8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en;
    logic        load;
    logic [2:0]  scan_idx;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int fails  = 0;
    int n      = 0;
    logic [7:0] prev_an = 8'hFF;

    seven_seg_scan_ctrl #(
        .CLK_DIV      (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
        .scan_idx   (scan_idx),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          at_n;
        logic        do_load;
        logic [31:0] ld_data;
        logic [7:0]  ld_en;
        logic [7:0]  ld_dp;
        logic [2:0]  e_idx;
        logic [7:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic        e_fd;
    } vec_t;

    vec_t vecs[$];

    // One clock edge, then the anode invariants on the new output
    task automatic step();
        @(posedge clk);
        #1;
        n++;
        checks++;
        if ($countones(~an) > 1) begin
            fails++;
            $display("FAIL onehot n=%0d an=%h (expected at most one low bit)", n, an);
        end
        checks++;
        if (an != prev_an && an != 8'hFF && prev_an != 8'hFF) begin
            fails++;
            $display("FAIL overlap n=%0d an %h -> %h without blank", n, prev_an, an);
        end
        prev_an = an;
    endtask

    task automatic check_out(input string name, input logic [2:0] e_idx,
                             input logic [7:0] e_an, input logic [6:0] e_seg,
                             input logic e_dp, input logic e_fd);
        checks++;
        if (scan_idx !== e_idx || an !== e_an || seg !== e_seg ||
            dp !== e_dp || frame_done !== e_fd) begin
            fails++;
            $display("FAIL %s n=%0d got idx=%0d an=%h seg=%b dp=%b fd=%b expected idx=%0d an=%h seg=%b dp=%b fd=%b",
                     name, n, scan_idx, an, seg, dp, frame_done,
                     e_idx, e_an, e_seg, e_dp, e_fd);
        end
    endtask

    task automatic add(input int at_n, input logic ld, input logic [31:0] d,
                       input logic [7:0] en, input logic [7:0] dpv,
                       input logic [2:0] ei, input logic [7:0] ea,
                       input logic [6:0] es, input logic ed, input logic ef);
        vec_t v;
        v.at_n = at_n; v.do_load = ld; v.ld_data = d; v.ld_en = en; v.ld_dp = dpv;
        v.e_idx = ei; v.e_an = ea; v.e_seg = es; v.e_dp = ed; v.e_fd = ef;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; data = '0; dp_in = '0; digit_en = '0; load = 1'b0;

        // Scan timing and blank content after reset
        add(  7, 0, 0, 0, 0, 3'd0, 8'hFF, 7'h7F, 1, 0);
        add(  8, 0, 0, 0, 0, 3'd1, 8'hFF, 7'h7F, 1, 0);
        // Load a word mid frame 0; still blank until the wrap
        add( 20, 1, 32'h76543210, 8'hFF, 8'h00, 3'd2, 8'hFF, 7'h7F, 1, 0);
        add( 63, 0, 0, 0, 0, 3'd7, 8'hFF, 7'h7F, 1, 0);
        add( 64, 0, 0, 0, 0, 3'd0, 8'hFF, 7'h7F, 1, 1);
        add( 65, 0, 0, 0, 0, 3'd0, 8'hFF, 7'h7F, 1, 0);
        add( 67, 0, 0, 0, 0, 3'd0, 8'hFE, 7'b1000000, 1, 0);
        add( 90, 0, 0, 0, 0, 3'd3, 8'hFF, 7'h7F, 1, 0);
        add( 91, 0, 0, 0, 0, 3'd3, 8'hF7, 7'b0110000, 1, 0);
        add(128, 0, 0, 0, 0, 3'd0, 8'h7F, 7'b1111000, 1, 1);
        // Odd digits only
        add(130, 1, 32'h76543210, 8'hAA, 8'h00, 3'd0, 8'hFF, 7'h7F, 1, 0);
        add(205, 0, 0, 0, 0, 3'd1, 8'hFD, 7'b1111001, 1, 0);
        add(212, 0, 0, 0, 0, 3'd2, 8'hFF, 7'h7F, 1, 0);
        add(236, 0, 0, 0, 0, 3'd5, 8'hDF, 7'b0010010, 1, 0);
        // Load coincident with the 7->0 tick: old shadow goes active
        add(256, 1, 32'hFEDCBA98, 8'hFF, 8'h00, 3'd0, 8'h7F, 7'b1111000, 1, 1);
        add(260, 0, 0, 0, 0, 3'd0, 8'hFF, 7'h7F, 1, 0);
        add(316, 0, 0, 0, 0, 3'd7, 8'h7F, 7'b1111000, 1, 0);
        add(324, 0, 0, 0, 0, 3'd0, 8'hFE, 7'b0000000, 1, 0);
        add(380, 0, 0, 0, 0, 3'd7, 8'h7F, 7'b0001110, 1, 0);
        // Decimal point on digit 0
        add(390, 1, 32'hFEDCBA98, 8'hFF, 8'h01, 3'd0, 8'hFE, 7'b0000000, 1, 0);
        add(449, 0, 0, 0, 0, 3'd0, 8'hFF, 7'h7F, 1, 0);
        add(451, 0, 0, 0, 0, 3'd0, 8'hFE, 7'b0000000, 0, 0);
        add(460, 0, 0, 0, 0, 3'd1, 8'hFD, 7'b0010000, 1, 0);

        repeat (3) step();
        rst = 1'b0;
        n = 0;
        check_out("reset_state", 3'd0, 8'hFF, 7'h7F, 1, 0);

        foreach (vecs[k]) begin
            while (n < vecs[k].at_n - 1) step();
            if (vecs[k].do_load) begin
                load = 1'b1; data = vecs[k].ld_data;
                digit_en = vecs[k].ld_en; dp_in = vecs[k].ld_dp;
            end
            step();
            load = 1'b0;
            check_out($sformatf("vec%0d", k), vecs[k].e_idx, vecs[k].e_an,
                      vecs[k].e_seg, vecs[k].e_dp, vecs[k].e_fd);
        end

        // Reset mid-dwell of digit 5 (frame 8, count 3)
        while (n < 555) step();
        checks++;
        if (scan_idx !== 3'd5) begin
            fails++;
            $display("FAIL pre_rst_idx got %0d expected 5", scan_idx);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        check_out("mid_rst", 3'd0, 8'hFF, 7'h7F, 1, 0);
        while (n < 7) step();
        check_out("rst_pre_tick", 3'd0, 8'hFF, 7'h7F, 1, 0);
        step();
        check_out("rst_tick", 3'd1, 8'hFF, 7'h7F, 1, 0);
        // Old shadow was cleared: still blank after a wrap with no load
        while (n < 70) step();
        check_out("rst_blank", 3'd0, 8'hFF, 7'h7F, 1, 0);
        while (n < 79) step();
        load = 1'b1; data = 32'h76543210; digit_en = 8'hFF; dp_in = 8'h00;
        step();
        load = 1'b0;
        while (n < 128) step();
        check_out("rst_reload_wrap", 3'd0, 8'hFF, 7'h7F, 1, 1);
        while (n < 131) step();
        check_out("rst_reload_d0", 3'd0, 8'hFE, 7'b1000000, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
